// File: rtl/key_input_conditioner.sv
`timescale 1ns/1ps
// key_input_conditioner
// Turns the four raw active-low push-buttons into debounced single-frame
// request pulses for the game core, with optional DAS auto-repeat on the
// left/right channels.
//
// Build option: define KEY_AUTOREPEAT_EN to enable the IDLE/DELAY/REPEAT
// auto-repeat on left/right; otherwise left/right pulse once per press.
//
// Ports
//   clock_framerate  frame-rate clock, rising edge
//   resetn           synchronous active-low reset
//   raw_left_n, raw_right_n, raw_rotate_n, raw_start_n
//                    asynchronous buttons, 0 = pressed
//   key_left, key_right, key_rotate
//                    registered one-frame move/rotate pulses
//   start_game       registered one-frame start pulse
//   any_held         registered OR of the debounced levels
module key_input_conditioner #(
  parameter int unsigned DEBOUNCE_FRAMES = 2,
  parameter int unsigned DAS_DELAY       = 10,
  parameter int unsigned DAS_RATE        = 4
) (
  input  logic clock_framerate,
  input  logic resetn,
  input  logic raw_left_n,
  input  logic raw_right_n,
  input  logic raw_rotate_n,
  input  logic raw_start_n,
  output logic key_left,
  output logic key_right,
  output logic key_rotate,
  output logic start_game,
  output logic any_held
);

  localparam int unsigned NCH    = 4;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned CH_L   = 0;
  localparam int unsigned CH_R   = 1;
  localparam int unsigned CH_ROT = 2;
  localparam int unsigned CH_ST  = 3;

  // Elaboration-time parameter range checks
  if (DEBOUNCE_FRAMES < 1 || DEBOUNCE_FRAMES > 15) begin : g_bad_debounce
    $error("DEBOUNCE_FRAMES out of range 1..15");
  end
  if (DAS_DELAY < 1 || DAS_DELAY > 63) begin : g_bad_das_delay
    $error("DAS_DELAY out of range 1..63");
  end
  if (DAS_RATE < 1 || DAS_RATE > 63) begin : g_bad_das_rate
    $error("DAS_RATE out of range 1..63");
  end

  logic [NCH-1:0]   raw_n;
  logic [NCH-1:0]   sync1_q, sync2_q;
  logic [NCH-1:0]   db_q, db_nxt;
  logic [CNT_W-1:0] cnt_q   [NCH];
  logic [CNT_W-1:0] cnt_nxt [NCH];
  logic [1:0]       rs_d_q;
  logic [1:0]       rs_pulse_c;
  logic [1:0]       lr_pulse_c;
  logic             conflict_c;

  assign raw_n = {raw_start_n, raw_rotate_n, raw_right_n, raw_left_n};

  // Two-flop synchronizer on the inverted (active-high) buttons
  always_ff @(posedge clock_framerate) begin
    if (!resetn) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= ~raw_n;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: accept a new level only after it differs for DEBOUNCE_FRAMES frames
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      db_nxt[i]  = db_q[i];
      cnt_nxt[i] = cnt_q[i];
      if (sync2_q[i] == db_q[i]) begin
        cnt_nxt[i] = '0;
      end else if (cnt_q[i] == CNT_W'(DEBOUNCE_FRAMES - 1)) begin
        db_nxt[i]  = sync2_q[i];
        cnt_nxt[i] = '0;
      end else begin
        cnt_nxt[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock_framerate) begin
    if (!resetn) begin
      db_q <= '0;
      for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
    end else begin
      db_q <= db_nxt;
      for (int i = 0; i < NCH; i++) cnt_q[i] <= cnt_nxt[i];
    end
  end

  // Both directions held: left/right are suppressed
  assign conflict_c = db_q[CH_L] & db_q[CH_R];

  // Rotate/start: rising edge of the debounced level, never repeats
  always_ff @(posedge clock_framerate) begin
    if (!resetn) rs_d_q <= '0;
    else         rs_d_q <= {db_q[CH_ST], db_q[CH_ROT]};
  end

  assign rs_pulse_c = {db_q[CH_ST], db_q[CH_ROT]} & ~rs_d_q;

`ifdef KEY_AUTOREPEAT_EN
  localparam int unsigned RCNT_W = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rep_state_e;

  rep_state_e        state_q   [2];
  rep_state_e        state_nxt [2];
  logic [RCNT_W-1:0] rcnt_q    [2];
  logic [RCNT_W-1:0] rcnt_nxt  [2];

  // DAS state registers for left (0) and right (1)
  always_ff @(posedge clock_framerate) begin
    if (!resetn) begin
      for (int j = 0; j < 2; j++) begin
        state_q[j] <= IDLE;
        rcnt_q[j]  <= '0;
      end
    end else begin
      for (int j = 0; j < 2; j++) begin
        state_q[j] <= state_nxt[j];
        rcnt_q[j]  <= rcnt_nxt[j];
      end
    end
  end

  // DAS next-state: release wins, then conflict parks both in DELAY at 0
  always_comb begin
    for (int j = 0; j < 2; j++) begin
      state_nxt[j]  = state_q[j];
      rcnt_nxt[j]   = rcnt_q[j];
      lr_pulse_c[j] = 1'b0;
      if (!db_q[j]) begin
        state_nxt[j] = IDLE;
        rcnt_nxt[j]  = '0;
      end else if (conflict_c) begin
        state_nxt[j] = DELAY;
        rcnt_nxt[j]  = '0;
      end else begin
        case (state_q[j])
          IDLE: begin
            lr_pulse_c[j] = 1'b1;
            rcnt_nxt[j]   = '0;
            state_nxt[j]  = DELAY;
          end
          DELAY: begin
            if (rcnt_q[j] == RCNT_W'(DAS_DELAY - 1)) begin
              lr_pulse_c[j] = 1'b1;
              rcnt_nxt[j]   = '0;
              state_nxt[j]  = REPEAT;
            end else begin
              rcnt_nxt[j] = rcnt_q[j] + RCNT_W'(1);
            end
          end
          REPEAT: begin
            if (rcnt_q[j] == RCNT_W'(DAS_RATE - 1)) begin
              lr_pulse_c[j] = 1'b1;
              rcnt_nxt[j]   = '0;
            end else begin
              rcnt_nxt[j] = rcnt_q[j] + RCNT_W'(1);
            end
          end
          default: begin
            state_nxt[j] = IDLE;
            rcnt_nxt[j]  = '0;
          end
        endcase
      end
    end
  end
`else
  logic [1:0] lr_d_q;

  // Single pulse per press; a press that starts during a conflict is dropped
  always_ff @(posedge clock_framerate) begin
    if (!resetn) lr_d_q <= '0;
    else         lr_d_q <= {db_q[CH_R], db_q[CH_L]};
  end

  assign lr_pulse_c = {db_q[CH_R], db_q[CH_L]} & ~lr_d_q & {2{~conflict_c}};
`endif

  // Registered outputs; any_held tracks the level being loaded into db
  always_ff @(posedge clock_framerate) begin
    if (!resetn) begin
      key_left   <= 1'b0;
      key_right  <= 1'b0;
      key_rotate <= 1'b0;
      start_game <= 1'b0;
      any_held   <= 1'b0;
    end else begin
      key_left   <= lr_pulse_c[0];
      key_right  <= lr_pulse_c[1];
      key_rotate <= rs_pulse_c[0];
      start_game <= rs_pulse_c[1];
      any_held   <= |db_nxt;
    end
  end

endmodule

// File: tb/tb_key_input_conditioner.sv
`timescale 1ns/1ps
// Directed bench for key_input_conditioner (default parameters).
// Per-edge output log: bit0 key_left, bit1 key_right, bit2 key_rotate,
// bit3 start_game, bit4 any_held. Edge 1 is the first edge that samples
// the new raw input value.
module tb_key_input_conditioner;

  logic clock_framerate = 1'b0;
  logic resetn          = 1'b0;
  logic raw_left_n      = 1'b1;
  logic raw_right_n     = 1'b1;
  logic raw_rotate_n    = 1'b1;
  logic raw_start_n     = 1'b1;
  logic key_left, key_right, key_rotate, start_game, any_held;

  int checks   = 0;
  int failures = 0;
  int ecount   = 0;
  logic [4:0]   lg [0:127];
  logic [127:0] m;

  key_input_conditioner dut (
    .clock_framerate (clock_framerate),
    .resetn          (resetn),
    .raw_left_n      (raw_left_n),
    .raw_right_n     (raw_right_n),
    .raw_rotate_n    (raw_rotate_n),
    .raw_start_n     (raw_start_n),
    .key_left        (key_left),
    .key_right       (key_right),
    .key_rotate      (key_rotate),
    .start_game      (start_game),
    .any_held        (any_held)
  );

  always #5 clock_framerate = ~clock_framerate;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock_framerate);
    #1;
    ecount++;
    lg[ecount] = {any_held, start_game, key_rotate, key_right, key_left};
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic idle();
    raw_left_n   = 1'b1;
    raw_right_n  = 1'b1;
    raw_rotate_n = 1'b1;
    raw_start_n  = 1'b1;
    run(10);
    ecount = 0;
  endtask

  function automatic int count_pulses(input int b, input int last);
    int n = 0;
    for (int e = 1; e <= last; e++) if (lg[e][b]) n++;
    return n;
  endfunction

  task automatic check_edges(input string tag, input int b, input int last, input logic [127:0] mask);
    for (int e = 1; e <= last; e++)
      check($sformatf("%s@%0d", tag, e), 32'(lg[e][b]), 32'(mask[e]));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    run(3);
    check("reset_outputs", 32'(lg[3]), 32'd0);
    resetn = 1'b1;
    idle();

    // Left held 30 frames
    raw_left_n = 1'b0;
    run(30);
    raw_left_n = 1'b1;
    run(10);
    m = '0;
    m[5] = 1'b1;
`ifdef KEY_AUTOREPEAT_EN
    m[15] = 1'b1; m[19] = 1'b1; m[23] = 1'b1; m[27] = 1'b1; m[31] = 1'b1;
`endif
    check_edges("left_hold", 0, 40, m);
    check("left_hold_right_cnt", 32'(count_pulses(1, 40)), 32'd0);

    // Rotate glitch of one frame is rejected
    idle();
    raw_rotate_n = 1'b0;
    run(1);
    raw_rotate_n = 1'b1;
    run(9);
    check("rot_glitch_cnt", 32'(count_pulses(2, 10)), 32'd0);
    check("rot_glitch_held", 32'(count_pulses(4, 10)), 32'd0);

    // Rotate pressed three frames: one pulse at edge 5
    idle();
    raw_rotate_n = 1'b0;
    run(3);
    raw_rotate_n = 1'b1;
    run(9);
    check("rot_press_e4", 32'(lg[4][2]), 32'd0);
    check("rot_press_e5", 32'(lg[5][2]), 32'd1);
    check("rot_press_cnt", 32'(count_pulses(2, 12)), 32'd1);

    // Start and rotate together, held 20 frames
    idle();
    raw_rotate_n = 1'b0;
    raw_start_n  = 1'b0;
    run(20);
    raw_rotate_n = 1'b1;
    raw_start_n  = 1'b1;
    run(10);
    check("both_start_e5", 32'(lg[5][3]), 32'd1);
    check("both_rot_e5", 32'(lg[5][2]), 32'd1);
    check("both_start_cnt", 32'(count_pulses(3, 30)), 32'd1);
    check("both_rot_cnt", 32'(count_pulses(2, 30)), 32'd1);
    check("held_e3", 32'(lg[3][4]), 32'd0);
    check("held_e4", 32'(lg[4][4]), 32'd1);
    check("held_e20", 32'(lg[20][4]), 32'd1);
    check("held_e23", 32'(lg[23][4]), 32'd1);
    check("held_e25", 32'(lg[25][4]), 32'd0);

    // Left held, right pressed mid-repeat, then right released
    idle();
    raw_left_n = 1'b0;
    run(20);
    raw_right_n = 1'b0;
    run(19);
    raw_right_n = 1'b1;
    run(12);
    raw_left_n = 1'b1;
    run(14);
    m = '0;
    m[5] = 1'b1;
`ifdef KEY_AUTOREPEAT_EN
    m[15] = 1'b1; m[19] = 1'b1; m[23] = 1'b1; m[53] = 1'b1;
`endif
    check_edges("conflict_left", 0, 65, m);
    check("conflict_right_cnt", 32'(count_pulses(1, 65)), 32'd0);

    // Reset for two frames mid-repeat with left still held
    idle();
    raw_left_n = 1'b0;
    run(20);
    resetn = 1'b0;
    run(2);
    resetn = 1'b1;
    run(24);
    raw_left_n = 1'b1;
    run(9);
    check("rst_out_e21", 32'(lg[21]), 32'd0);
    check("rst_out_e22", 32'(lg[22]), 32'd0);
    m = '0;
    m[5] = 1'b1; m[27] = 1'b1;
`ifdef KEY_AUTOREPEAT_EN
    m[15] = 1'b1; m[19] = 1'b1; m[37] = 1'b1; m[41] = 1'b1; m[45] = 1'b1; m[49] = 1'b1;
`endif
    check_edges("rst_left", 0, 55, m);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
